mux_nto1_rr_reg: RTL

- Parametrised N-input, WIDTH-bit multiplexer.
- Successor to the fixed 2:1 combinational data-flow mux in the combinational-logic set.
- Adds per-channel valid/ready handshakes, a registered output stage, and a runtime mode: fixed select or round-robin arbitration.
- Sits between multiple producers and a single consumer and merges their streams one word per cycle.

---
 rtl/mux_pkg.sv | 5 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/mux_nto1_rr_reg.sv | 77 +++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the registered N:1 stream multiplexer.
package mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... modulo N for the first request.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    // k = N wraps back to ptr itself, so a lone requester at ptr is re-granted
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr_reg.sv
// N-input stream mux with valid/ready per channel, fixed or round-robin selection,
// and a one-entry registered output stage.
module mux_nto1_rr_reg
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_ch
);

  logic [SEL_W-1:0] rr_ptr;
  logic [N-1:0]     rr_grant;
  logic [SEL_W-1:0] rr_idx;
  logic [N-1:0]     fixed_grant;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             load_en;
  logic             xfer;

  rr_arbiter #(
    .N(N)
  ) u_arb (
    .req      (in_valid),
    .ptr      (rr_ptr),
    .grant    (rr_grant),
    .grant_idx(rr_idx)
  );

  // Out-of-range sel grants nothing, so the output starves.
  always_comb begin
    fixed_grant = '0;
    if (32'(sel) < N) fixed_grant[sel] = in_valid[sel];
  end

  assign grant     = (mode == MODE_RR) ? rr_grant : fixed_grant;
  assign grant_idx = (mode == MODE_RR) ? rr_idx : sel;
  assign load_en   = !out_valid || out_ready;
  assign in_ready  = grant & {N{load_en && !rst}};
  assign xfer      = |(in_valid & in_ready);

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant_idx;
      if (mode == MODE_RR) rr_ptr <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
